regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the in-order pipeline WB stage and a long-latency unit (mul/div or load miss) with a valid/ready handshake.
- Buffers unit results in a small FIFO and drives RegWrite/RDaddr/RDdata of the register file.
- Exports a per-register pending mask for decode RAW-stall logic.
- Forces a pipeline stall when buffered results starve.

Parameters:
- REG_LEN, 32, data width.
- REG_NUM_BITS, 5, register index width.
- DEPTH, 2, unit-result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_o asserts.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- pipe_valid_i  in  1  pipeline WB stage has a write.
- pipe_rd_i  in  REG_NUM_BITS  pipeline destination register.
- pipe_data_i  in  REG_LEN  pipeline write data.
- pipe_grant_o  out  1  pipeline write accepted this cycle.
- stall_o  out  1  pipeline must hold its WB stage this cycle.
- unit_valid_i  in  1  unit result offered.
- unit_rd_i  in  REG_NUM_BITS  unit destination register.
- unit_data_i  in  REG_LEN  unit result data.
- unit_ready_o  out  1  FIFO can accept a unit result.
- RegWrite_o  out  1  register-file write enable.
- RDaddr_o  out  REG_NUM_BITS  register-file write address.
- RDdata_o  out  REG_LEN  register-file write data.
- pending_o  out  2^REG_NUM_BITS  bit r is set when a live FIFO entry targets register r.
- count_o  out  clog2(DEPTH)+1  FIFO occupancy, including killed entries.

Behaviour:
- Reset, asynchronous and immediate:
  - FIFO emptied, all entries invalidated, starve counter cleared.
  - stall_o, pending_o, count_o are 0. unit_ready_o is 0 while rst_i is high.
  - RegWrite_o, pipe_grant_o are 0 while rst_i is high, regardless of inputs.
- FIFO entry holds {live, rd, data}.
- Enqueue occurs on unit_valid_i && unit_ready_o.
  - rd==0 results are accepted and discarded, not enqueued.
- unit_ready_o = (count_o < DEPTH). It does not account for a same-cycle pop.
- Head is "live" if its live bit is set. Killed heads pop in any cycle without writing and without using the port.
- Port selection, combinational, evaluated each cycle:
  - stall_o=1 and live head present: head writes; pipe_grant_o=0.
  - Otherwise, pipe_valid_i=1: pipe writes; pipe_grant_o=1.
  - Otherwise, live head present: head writes and pops.
  - Otherwise: RegWrite_o=0.
- The pipeline holds its WB contents while stall_o is high.
- A pipe write to rd==0 is granted but RegWrite_o=0.
- RDaddr_o and RDdata_o follow the selected source. They are don't-care when RegWrite_o=0.
- WAW kill: a granted pipe write to rd≠0 clears the live bit of every FIFO entry with the same rd at the clock edge.
  - This includes an entry enqueued in the same cycle.
  - The core's issue rule makes pipe writes always younger than in-flight unit results.
- Starve counter:
  - Increments each cycle a live head exists and is not written.
  - Clears when the head pops or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_o = (counter == STARVE_LIMIT).
- Same-cycle enqueue and pop are both applied; count is unchanged. Pointers wrap modulo DEPTH.
- pending_o is the OR of one-hot(rd) over live entries. It is registered and reflects post-edge state, so kills and pops clear bits the next cycle.
- No combinational path exists from unit_valid_i to unit_ready_o.

Test Plan:
- Idle drain:
  - Stimulus: unit writes rd=3, data=0xDEADBEEF; pipe idle.
  - Response: count_o=1 and pending_o[3]=1 next cycle.
  - Following cycle: RegWrite_o=1, RDaddr_o=3, RDdata_o=0xDEADBEEF; count_o then returns to 0.
- Priority:
  - Stimulus: FIFO holds rd=4; pipe_valid_i=1 with rd=7 for 2 cycles.
  - Response: pipe writes rd=7 on both cycles with pipe_grant_o=1; rd=4 drains on the first idle cycle.
- Starvation:
  - Stimulus: FIFO holds rd=9; pipe_valid_i held at 1.
  - Response: stall_o=1 after 4 blocked cycles.
  - That cycle: RegWrite_o=1, RDaddr_o=9, pipe_grant_o=0.
  - Next cycle: stall_o=0 and the pipe is granted.
- WAW kill:
  - Stimulus: FIFO holds rd=5 with data 0x11; pipe writes rd=5 with data 0x22.
  - Response: pending_o[5]=0 next cycle; the entry pops with RegWrite_o=0, so x5 keeps 0x22.
- Full/wrap:
  - Stimulus: DEPTH=2; pipe busy; unit offers 3 results.
  - Response: unit_ready_o=0 after 2 enqueues.
  - Pipe releases: entries drain in order, the third result enqueues, and pointers wrap correctly across 6 total transfers.
- Reset mid-operation:
  - Stimulus: rst_i pulsed with count_o=2 and stall_o=1.
  - Response: count_o=0, stall_o=0, pending_o=0 and RegWrite_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle between the WB arbiter, its two result sources and the register file.
// The arbiter side uses the slave modport; the driver/observer side uses the master modport.
interface regfile_wb_arbiter_if #(
    parameter int unsigned REG_LEN      = 32,
    parameter int unsigned REG_NUM_BITS = 5,
    parameter int unsigned DEPTH        = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned NREG  = 1 << REG_NUM_BITS;

    logic                    pipe_valid_i;
    logic [REG_NUM_BITS-1:0] pipe_rd_i;
    logic [REG_LEN-1:0]      pipe_data_i;
    logic                    pipe_grant_o;
    logic                    stall_o;
    logic                    unit_valid_i;
    logic [REG_NUM_BITS-1:0] unit_rd_i;
    logic [REG_LEN-1:0]      unit_data_i;
    logic                    unit_ready_o;
    logic                    RegWrite_o;
    logic [REG_NUM_BITS-1:0] RDaddr_o;
    logic [REG_LEN-1:0]      RDdata_o;
    logic [NREG-1:0]         pending_o;
    logic [CNT_W-1:0]        count_o;

    modport slave (
        input  pipe_valid_i, pipe_rd_i, pipe_data_i, unit_valid_i, unit_rd_i, unit_data_i,
        output pipe_grant_o, stall_o, unit_ready_o, RegWrite_o, RDaddr_o, RDdata_o,
               pending_o, count_o
    );

    modport master (
        output pipe_valid_i, pipe_rd_i, pipe_data_i, unit_valid_i, unit_rd_i, unit_data_i,
        input  pipe_grant_o, stall_o, unit_ready_o, RegWrite_o, RDaddr_o, RDdata_o,
               pending_o, count_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline WB stage and a buffered
// long-latency unit, with WAW kill, a registered pending mask and starvation stall.
module regfile_wb_arbiter #(
    parameter int unsigned REG_LEN      = 32,
    parameter int unsigned REG_NUM_BITS = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 1 << REG_NUM_BITS;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [REG_NUM_BITS-1:0] r_rd   [DEPTH];
    logic [REG_LEN-1:0]      r_data [DEPTH];
    logic [DEPTH-1:0]        r_live;
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_count;
    logic [STV_W-1:0]        r_starve;
    logic [NREG-1:0]         r_pending;

    logic [REG_NUM_BITS-1:0] w_rd_d   [DEPTH];
    logic [REG_LEN-1:0]      w_data_d [DEPTH];
    logic [DEPTH-1:0]        w_live_d;
    logic [CNT_W-1:0]        w_count_d;
    logic [STV_W-1:0]        w_starve_d;
    logic [NREG-1:0]         w_pending_d;

    logic                    w_head_valid;
    logic                    w_head_live;
    logic                    w_stall;
    logic                    w_ready;
    logic                    w_head_wr;
    logic                    w_grant;
    logic                    w_we;
    logic [REG_NUM_BITS-1:0] w_addr;
    logic [REG_LEN-1:0]      w_data;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_kill;

    // Live bits are cleared on pop, so a set bit always marks an occupied entry.
    assign w_head_valid = (r_count != '0);
    assign w_head_live  = w_head_valid && r_live[r_rptr];
    assign w_stall      = (r_starve == STV_W'(STARVE_LIMIT));
    assign w_ready      = !rst_i && (r_count < CNT_W'(DEPTH));

    always_comb begin
        w_we      = 1'b0;
        w_addr    = bus.pipe_rd_i;
        w_data    = bus.pipe_data_i;
        w_grant   = 1'b0;
        w_head_wr = 1'b0;
        if (!rst_i) begin
            if (w_stall && w_head_live) begin
                w_head_wr = 1'b1;
            end else if (bus.pipe_valid_i) begin
                w_grant = 1'b1;
                w_we    = (bus.pipe_rd_i != '0);
            end else if (w_head_live) begin
                w_head_wr = 1'b1;
            end
        end
        if (w_head_wr) begin
            w_we   = 1'b1;
            w_addr = r_rd[r_rptr];
            w_data = r_data[r_rptr];
        end
    end

    // Killed heads drain without touching the write port.
    assign w_pop  = !rst_i && w_head_valid && (!w_head_live || w_head_wr);
    assign w_push = bus.unit_valid_i && w_ready && (bus.unit_rd_i != '0);
    assign w_kill = w_grant && (bus.pipe_rd_i != '0);

    always_comb begin
        w_rd_d      = r_rd;
        w_data_d    = r_data;
        w_live_d    = r_live;
        w_pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pop && (r_rptr == PTR_W'(i))) w_live_d[i] = 1'b0;
            if (w_kill && (r_rd[i] == bus.pipe_rd_i)) w_live_d[i] = 1'b0;
            if (w_push && (r_wptr == PTR_W'(i))) begin
                w_rd_d[i]   = bus.unit_rd_i;
                w_data_d[i] = bus.unit_data_i;
                w_live_d[i] = !(w_kill && (bus.unit_rd_i == bus.pipe_rd_i));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live_d[i]) w_pending_d[w_rd_d[i]] = 1'b1;
        end
        w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_head_live && !w_pop) begin
            w_starve_d = w_stall ? r_starve : r_starve + STV_W'(1);
        end else begin
            w_starve_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_live    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
        end else begin
            r_rd      <= w_rd_d;
            r_data    <= w_data_d;
            r_live    <= w_live_d;
            r_wptr    <= r_wptr + PTR_W'(w_push);
            r_rptr    <= r_rptr + PTR_W'(w_pop);
            r_count   <= w_count_d;
            r_starve  <= w_starve_d;
            r_pending <= w_pending_d;
        end
    end

    assign bus.pipe_grant_o = w_grant;
    assign bus.stall_o      = w_stall;
    assign bus.unit_ready_o = w_ready;
    assign bus.RegWrite_o   = w_we;
    assign bus.RDaddr_o     = w_addr;
    assign bus.RDdata_o     = w_data;
    assign bus.pending_o    = r_pending;
    assign bus.count_o      = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter with a register-file model on the write port.
module tb_regfile_wb_arbiter;
    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        uv;
        logic [4:0]  urd;
        logic [31:0] udat;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        grant;
        logic        stall;
        logic        ready;
        logic [1:0]  cnt;
        logic [31:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass = 0;
    logic [31:0] rf [32];
    vec_t vq [$];

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.REG_LEN(32), .REG_NUM_BITS(5), .DEPTH(2)) bus ();

    regfile_wb_arbiter #(
        .REG_LEN(32), .REG_NUM_BITS(5), .DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always @(posedge clk) begin
        if (bus.RegWrite_o) rf[bus.RDaddr_o] <= bus.RDdata_o;
    end

    function automatic vec_t mk(input int unsigned pv, prd, pdat, uv, urd, udat,
                                input int unsigned we, addr, data, grant, stall, ready,
                                input int unsigned cnt, pend);
        vec_t r;
        r.pv = 1'(pv);   r.prd = 5'(prd);   r.pdat = pdat;
        r.uv = 1'(uv);   r.urd = 5'(urd);   r.udat = udat;
        r.we = 1'(we);   r.addr = 5'(addr); r.data = data;
        r.grant = 1'(grant); r.stall = 1'(stall); r.ready = 1'(ready);
        r.cnt = 2'(cnt); r.pend = pend;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t v);
        bus.pipe_valid_i = v.pv;
        bus.pipe_rd_i    = v.prd;
        bus.pipe_data_i  = v.pdat;
        bus.unit_valid_i = v.uv;
        bus.unit_rd_i    = v.urd;
        bus.unit_data_i  = v.udat;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk("RegWrite", idx, 32'(bus.RegWrite_o), 32'(v.we));
        if (v.we) begin
            chk("RDaddr", idx, 32'(bus.RDaddr_o), 32'(v.addr));
            chk("RDdata", idx, bus.RDdata_o, v.data);
        end
        chk("pipe_grant", idx, 32'(bus.pipe_grant_o), 32'(v.grant));
        chk("stall", idx, 32'(bus.stall_o), 32'(v.stall));
        chk("unit_ready", idx, 32'(bus.unit_ready_o), 32'(v.ready));
        chk("count", idx, 32'(bus.count_o), 32'(v.cnt));
        chk("pending", idx, bus.pending_o, v.pend);
    endtask

    initial begin
        vec_t v;
        // pv prd pdat       uv urd udat       we addr data   gnt stl rdy cnt pend
        vq.push_back(mk(0, 0, 0,      1, 3, 32'hDEADBEEF, 0, 0, 0,            0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,            1, 3, 32'hDEADBEEF, 0, 0, 1, 1, 32'h8));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,      1, 4, 32'h44,       0, 0, 0,            0, 0, 1, 0, 0));
        vq.push_back(mk(1, 7, 32'h77, 0, 0, 0,            1, 7, 32'h77,       1, 0, 1, 1, 32'h10));
        vq.push_back(mk(1, 7, 32'h78, 0, 0, 0,            1, 7, 32'h78,       1, 0, 1, 1, 32'h10));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,            1, 4, 32'h44,       0, 0, 1, 1, 32'h10));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0));
        // starvation: head rd=9 blocked for four cycles
        vq.push_back(mk(0, 0, 0,       1, 9, 32'h99, 0, 0, 0,        0, 0, 1, 0, 0));
        vq.push_back(mk(1, 1, 32'h101, 0, 0, 0,      1, 1, 32'h101,  1, 0, 1, 1, 32'h200));
        vq.push_back(mk(1, 1, 32'h102, 0, 0, 0,      1, 1, 32'h102,  1, 0, 1, 1, 32'h200));
        vq.push_back(mk(1, 1, 32'h103, 0, 0, 0,      1, 1, 32'h103,  1, 0, 1, 1, 32'h200));
        vq.push_back(mk(1, 1, 32'h104, 0, 0, 0,      1, 1, 32'h104,  1, 0, 1, 1, 32'h200));
        vq.push_back(mk(1, 1, 32'h105, 0, 0, 0,      1, 9, 32'h99,   0, 1, 1, 1, 32'h200));
        vq.push_back(mk(1, 1, 32'h105, 0, 0, 0,      1, 1, 32'h105,  1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0,        0, 0, 1, 0, 0));
        // WAW kill of a buffered entry
        vq.push_back(mk(0, 0, 0,      1, 5, 32'h11, 0, 0, 0,       0, 0, 1, 0, 0));
        vq.push_back(mk(1, 5, 32'h22, 0, 0, 0,      1, 5, 32'h22,  1, 0, 1, 1, 32'h20));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0));
        // kill of an entry enqueued in the same cycle
        vq.push_back(mk(1, 6, 32'h60, 1, 6, 32'h66, 1, 6, 32'h60,  1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0));
        // rd==0 from both sources
        vq.push_back(mk(1, 0, 32'hAB, 1, 0, 32'h1,  0, 0, 0,       1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 1, 0, 0));
        // full and wrap with DEPTH=2
        vq.push_back(mk(1, 2, 32'h200, 1, 10, 32'hA0, 1, 2, 32'h200, 1, 0, 1, 0, 0));
        vq.push_back(mk(1, 2, 32'h201, 1, 11, 32'hB0, 1, 2, 32'h201, 1, 0, 1, 1, 32'h400));
        vq.push_back(mk(1, 2, 32'h202, 1, 12, 32'hC0, 1, 2, 32'h202, 1, 0, 0, 2, 32'hC00));
        vq.push_back(mk(0, 0, 0,       1, 12, 32'hC0, 1, 10, 32'hA0, 0, 0, 0, 2, 32'hC00));
        vq.push_back(mk(0, 0, 0,       1, 12, 32'hC0, 1, 11, 32'hB0, 0, 0, 1, 1, 32'h800));
        vq.push_back(mk(0, 0, 0,       0, 0, 0,       1, 12, 32'hC0, 0, 0, 1, 1, 32'h1000));
        vq.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 1, 0, 0));
        // build up count=2 with a starving head ahead of the reset test
        vq.push_back(mk(1, 1, 32'h300, 1, 13, 32'hD0, 1, 1, 32'h300, 1, 0, 1, 0, 0));
        vq.push_back(mk(1, 1, 32'h301, 1, 14, 32'hE0, 1, 1, 32'h301, 1, 0, 1, 1, 32'h2000));
        vq.push_back(mk(1, 1, 32'h302, 0, 0, 0,       1, 1, 32'h302, 1, 0, 0, 2, 32'h6000));
        vq.push_back(mk(1, 1, 32'h303, 0, 0, 0,       1, 1, 32'h303, 1, 0, 0, 2, 32'h6000));
        vq.push_back(mk(1, 1, 32'h304, 0, 0, 0,       1, 1, 32'h304, 1, 0, 0, 2, 32'h6000));

        // outputs held low during reset even with both sources requesting
        drive(mk(1, 2, 32'h5, 1, 3, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_RegWrite", -1, 32'(bus.RegWrite_o), 32'd0);
        chk("rst_grant", -1, 32'(bus.pipe_grant_o), 32'd0);
        chk("rst_ready", -1, 32'(bus.unit_ready_o), 32'd0);
        chk("rst_count", -1, 32'(bus.count_o), 32'd0);
        chk("rst_stall", -1, 32'(bus.stall_o), 32'd0);
        chk("rst_pending", -1, bus.pending_o, 32'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check_vec(i, vq[i]);
        end

        // reset pulse with count=2 and stall asserted
        @(negedge clk);
        v = mk(1, 1, 32'h305, 0, 0, 0, 1, 13, 32'hD0, 0, 1, 0, 2, 32'h6000);
        drive(v);
        #1;
        check_vec(100, v);
        #2 rst = 1'b1;
        #1;
        chk("async_count", 101, 32'(bus.count_o), 32'd0);
        chk("async_stall", 101, 32'(bus.stall_o), 32'd0);
        chk("async_pending", 101, bus.pending_o, 32'd0);
        chk("async_RegWrite", 101, 32'(bus.RegWrite_o), 32'd0);
        chk("async_grant", 101, 32'(bus.pipe_grant_o), 32'd0);
        chk("async_ready", 101, 32'(bus.unit_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_vec(102, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // register-file contents seen through the write port
        chk("x3", 200, rf[3], 32'hDEADBEEF);
        chk("x4", 200, rf[4], 32'h44);
        chk("x7", 200, rf[7], 32'h78);
        chk("x9", 200, rf[9], 32'h99);
        chk("x5", 200, rf[5], 32'h22);
        chk("x6", 200, rf[6], 32'h60);
        chk("x10", 200, rf[10], 32'hA0);
        chk("x11", 200, rf[11], 32'hB0);
        chk("x12", 200, rf[12], 32'hC0);
        chk("x1", 200, rf[1], 32'h304);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
